// File: rtl/free_list.sv
// Physical register free list: an N-entry circular FIFO with a speculative
// allocation pointer (head), a retired-allocation pointer (arch_head) and a release pointer (tail).
module free_list #(
  parameter int PHYS_REGS      = 128,
  parameter int ARCH_REGS      = 64,
  parameter int DISPATCH_WIDTH = 1,
  parameter int COMMIT_WIDTH   = 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [DISPATCH_WIDTH-1:0]                        alloc_req_i,
  output logic [DISPATCH_WIDTH-1:0]                        alloc_valid_o,
  output logic [DISPATCH_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] alloc_prf_o,
  output logic [$clog2(PHYS_REGS+1)-1:0]                   free_count_o,
  input  logic [COMMIT_WIDTH-1:0]                          commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]                          commit_rd_wen_i,
  input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]   commit_old_prf_i,
  input  logic                                             flush_i
);
  localparam int N  = PHYS_REGS - ARCH_REGS;
  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;
  localparam int RW = $clog2(PHYS_REGS);
  localparam int FW = $clog2(PHYS_REGS + 1);

  logic [RW-1:0]                   fifo_r [N];
  logic [PW-1:0]                   head_r;
  logic [PW-1:0]                   tail_r;
  logic [PW-1:0]                   arch_head_r;
  logic [PW-1:0]                   free_s;
  logic [PW-1:0]                   grant_cnt_s;
  logic [PW-1:0]                   commit_cnt_s;
  logic [PW-1:0]                   head_next_s;
  logic [PW-1:0]                   tail_next_s;
  logic [PW-1:0]                   arch_next_s;
  logic [PW-1:0]                   count_next_s;
  logic [COMMIT_WIDTH-1:0]         commit_we_s;
  logic [COMMIT_WIDTH-1:0][IW-1:0] commit_idx_s;

  // Grant lanes in order; lane i takes the k-th free entry where k counts lower-lane grants
  always_comb begin
    free_s        = tail_r - head_r;
    grant_cnt_s   = {PW{1'b0}};
    alloc_valid_o = {DISPATCH_WIDTH{1'b0}};
    alloc_prf_o   = {(DISPATCH_WIDTH*RW){1'b0}};
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (alloc_req_i[i] && !flush_i && !reset && (free_s > grant_cnt_s)) begin
        alloc_valid_o[i] = 1'b1;
        alloc_prf_o[i]   = fifo_r[IW'(head_r + grant_cnt_s)];
        grant_cnt_s      = grant_cnt_s + PW'(1);
      end else begin
        alloc_valid_o[i] = 1'b0;
      end
    end
  end

  // Compact the qualifying release lanes into consecutive slots starting at tail
  always_comb begin
    commit_cnt_s = {PW{1'b0}};
    commit_we_s  = {COMMIT_WIDTH{1'b0}};
    commit_idx_s = {(COMMIT_WIDTH*IW){1'b0}};
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (commit_valid_i[j] && commit_rd_wen_i[j]) begin
        commit_we_s[j]  = 1'b1;
        commit_idx_s[j] = IW'(tail_r + commit_cnt_s);
        commit_cnt_s    = commit_cnt_s + PW'(1);
      end else begin
        commit_we_s[j] = 1'b0;
      end
    end
  end

  // Next pointer values; a flush rewinds head onto the post-commit arch_head
  always_comb begin
    tail_next_s = tail_r + commit_cnt_s;
    arch_next_s = arch_head_r + commit_cnt_s;
    if (flush_i) begin
      head_next_s = arch_next_s;
    end else begin
      head_next_s = head_r + grant_cnt_s;
    end
    count_next_s = tail_next_s - head_next_s;
  end

  // Pointer, storage and free-count state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r       <= {PW{1'b0}};
      arch_head_r  <= {PW{1'b0}};
      tail_r       <= PW'(N);
      free_count_o <= FW'(N);
      for (int i = 0; i < N; i++) begin
        fifo_r[i] <= RW'(ARCH_REGS + i);
      end
    end else begin
      head_r       <= head_next_s;
      tail_r       <= tail_next_s;
      arch_head_r  <= arch_next_s;
      free_count_o <= FW'(count_next_s);
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_we_s[j]) begin
          fifo_r[commit_idx_s[j]] <= commit_old_prf_i[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list (2 dispatch / 2 commit lanes): directed vector tables,
// hand-written corner sequences and a queue-based reference model under random stimulus.
module tb_free_list;
  localparam int N = 64;

  typedef struct packed {
    logic [1:0] req;
    logic       flush;
    logic [1:0] cv;
    logic [1:0] cw;
    logic [6:0] old0;
    logic [6:0] old1;
    logic [1:0] ev;
    logic [6:0] ep0;
    logic [6:0] ep1;
    logic [7:0] efc;
  } vec_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      alloc_req_i = 2'b00;
  logic [1:0]      alloc_valid_o;
  logic [1:0][6:0] alloc_prf_o;
  logic [7:0]      free_count_o;
  logic [1:0]      commit_valid_i = 2'b00;
  logic [1:0]      commit_rd_wen_i = 2'b00;
  logic [1:0][6:0] commit_old_prf_i = 14'd0;
  logic            flush_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int free_q[$];
  int infl_q[$];
  int arch_q[$];
  vec_t vt[11];

  free_list #(.PHYS_REGS(128), .ARCH_REGS(64), .DISPATCH_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clock(clock), .reset(reset),
    .alloc_req_i(alloc_req_i), .alloc_valid_o(alloc_valid_o), .alloc_prf_o(alloc_prf_o),
    .free_count_o(free_count_o),
    .commit_valid_i(commit_valid_i), .commit_rd_wen_i(commit_rd_wen_i),
    .commit_old_prf_i(commit_old_prf_i), .flush_i(flush_i)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [1:0] req, input logic flush, input logic [1:0] cv,
                              input logic [1:0] cw, input logic [6:0] old0, input logic [6:0] old1,
                              input logic [1:0] ev, input logic [6:0] ep0, input logic [6:0] ep1,
                              input logic [7:0] efc);
    vec_t v;
    v = {req, flush, cv, cw, old0, old1, ev, ep0, ep1, efc};
    return v;
  endfunction

  function automatic bit contains(input int q[$], input int val);
    foreach (q[n]) if (q[n] == val) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alloc_req_i         = v.req;
    flush_i             = v.flush;
    commit_valid_i      = v.cv;
    commit_rd_wen_i     = v.cw;
    commit_old_prf_i[0] = v.old0;
    commit_old_prf_i[1] = v.old1;
    @(negedge clock);
  endtask

  task automatic chk_comb(input string tag, input vec_t v);
    chk({tag, ".valid"}, 32'(alloc_valid_o), 32'(v.ev));
    chk({tag, ".prf0"}, 32'(alloc_prf_o[0]), 32'(v.ep0));
    chk({tag, ".prf1"}, 32'(alloc_prf_o[1]), 32'(v.ep1));
  endtask

  task automatic chk_edge(input string tag, input logic [7:0] efc);
    logic [6:0] d;
    @(posedge clock);
    #1;
    d = dut.tail_r - dut.arch_head_r;
    chk({tag, ".free_count"}, 32'(free_count_o), 32'(efc));
    chk({tag, ".tail_minus_arch"}, 32'(d), 32'(N));
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    chk_comb(tag, v);
    chk_edge(tag, v.efc);
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    arch_q.delete();
    for (int i = 0; i < N; i++) begin
      free_q.push_back(64 + i);
      arch_q.push_back(i);
    end
  endtask

  // Asserted with requests and commits active; both must be ignored
  task automatic do_reset(input string tag);
    alloc_req_i      = 2'b11;
    flush_i          = 1'b0;
    commit_valid_i   = 2'b11;
    commit_rd_wen_i  = 2'b11;
    commit_old_prf_i = 14'h1555;
    reset            = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, 32'(alloc_valid_o), 32'd0);
    chk({tag, ".rst_prf"}, 32'(alloc_prf_o), 32'd0);
    chk({tag, ".rst_count_async"}, 32'(free_count_o), 32'(N));
    @(posedge clock);
    #1;
    chk({tag, ".rst_count"}, 32'(free_count_o), 32'(N));
    reset           = 1'b0;
    alloc_req_i     = 2'b00;
    commit_valid_i  = 2'b00;
    commit_rd_wen_i = 2'b00;
    model_reset();
  endtask

  initial begin
    logic [6:0] t0;
    // {req, flush, cv, cw, old0, old1, exp_valid, exp_prf0, exp_prf1, exp_free_count}
    vt[0]  = mk(2'b01, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b01, 7'd64, 7'd0,  8'd63);
    vt[1]  = mk(2'b01, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b01, 7'd65, 7'd0,  8'd62);
    vt[2]  = mk(2'b01, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b01, 7'd66, 7'd0,  8'd61);
    vt[3]  = mk(2'b01, 1'b0, 2'b01, 2'b00, 7'd9,  7'd0,  2'b01, 7'd67, 7'd0,  8'd60);
    vt[4]  = mk(2'b00, 1'b0, 2'b01, 2'b01, 7'd3,  7'd0,  2'b00, 7'd0,  7'd0,  8'd61);
    vt[5]  = mk(2'b01, 1'b1, 2'b00, 2'b00, 7'd0,  7'd0,  2'b00, 7'd0,  7'd0,  8'd64);
    vt[6]  = mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b11, 7'd65, 7'd66, 8'd62);
    vt[7]  = mk(2'b10, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b10, 7'd0,  7'd67, 8'd61);
    vt[8]  = mk(2'b00, 1'b0, 2'b11, 2'b11, 7'd10, 7'd11, 2'b00, 7'd0,  7'd0,  8'd63);
    vt[9]  = mk(2'b11, 1'b1, 2'b01, 2'b01, 7'd12, 7'd0,  2'b00, 7'd0,  7'd0,  8'd64);
    vt[10] = mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0,  7'd0,  2'b11, 7'd68, 7'd69, 8'd62);

    #2;
    do_reset("init");
    for (int i = 0; i < 11; i++) begin
      t0 = dut.tail_r;
      apply($sformatf("vec%0d", i), vt[i]);
      if (i == 3) chk("vec3.tail_hold", 32'(dut.tail_r), 32'(t0));
    end

    // Drain the list, then release one register while it is empty
    do_reset("exhaust");
    for (int i = 0; i < 32; i++)
      apply($sformatf("drain%0d", i),
            mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 2'b11, 7'(64 + 2*i), 7'(65 + 2*i), 8'(62 - 2*i)));
    apply("empty",       mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 2'b00, 7'd0, 7'd0, 8'd0));
    apply("no_bypass",   mk(2'b01, 1'b0, 2'b01, 2'b01, 7'd5, 7'd0, 2'b00, 7'd0, 7'd0, 8'd1));
    apply("one_left",    mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 2'b01, 7'd5, 7'd0, 8'd0));
    apply("empty_again", mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 2'b00, 7'd0, 7'd0, 8'd0));

    // Random traffic against the queue model: free, in-flight and architecturally mapped sets
    do_reset("random");
    for (int c = 0; c < 800; c++) begin
      vec_t v;
      int   avail;
      int   k;
      int   idx;
      int   p;
      bit   ql[2];
      int   oldv[2];
      v = '0;
      v.req   = 2'($urandom_range(0, 3));
      v.flush = ($urandom_range(0, 15) == 0);
      avail   = infl_q.size();
      for (int j = 0; j < 2; j++) begin
        v.cv[j] = 1'($urandom_range(0, 1));
        v.cw[j] = 1'($urandom_range(0, 1));
        ql[j]   = 1'b0;
        oldv[j] = int'($urandom_range(0, 127));
        if (v.cv[j] && v.cw[j]) begin
          if (avail > 0) begin
            avail--;
            ql[j]   = 1'b1;
            idx     = int'($urandom_range(0, arch_q.size() - 1));
            oldv[j] = arch_q[idx];
            arch_q.delete(idx);
          end else begin
            v.cw[j] = 1'b0;
          end
        end
      end
      v.old0 = 7'(oldv[0]);
      v.old1 = 7'(oldv[1]);
      k = 0;
      for (int i = 0; i < 2; i++) begin
        if (v.req[i] && !v.flush && free_q.size() > k) begin
          v.ev[i] = 1'b1;
          if (i == 0) v.ep0 = 7'(free_q[k]);
          else        v.ep1 = 7'(free_q[k]);
          k++;
        end
      end
      drive(v);
      chk_comb("rand", v);
      for (int i = 0; i < 2; i++) begin
        if (alloc_valid_o[i]) begin
          p = int'(alloc_prf_o[i]);
          chk("rand.dup", 32'(contains(infl_q, p) || contains(arch_q, p)), 32'd0);
        end
      end
      repeat (k) infl_q.push_back(free_q.pop_front());
      for (int j = 0; j < 2; j++) begin
        if (ql[j]) begin
          arch_q.push_back(infl_q.pop_front());
          free_q.push_back(oldv[j]);
        end
      end
      if (v.flush) begin
        while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
      end
      chk_edge("rand", 8'(free_q.size()));
    end

    // Reset in the middle of traffic restores the initial list
    do_reset("midreset");
    apply("after_reset", mk(2'b11, 1'b0, 2'b00, 2'b00, 7'd0, 7'd0, 2'b11, 7'd64, 7'd65, 8'd62));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 128, physical register count.
REQ-002 SHALL have parameter ARCH_REGS, default 64, architectural register count; N = PHYS_REGS-ARCH_REGS is the FIFO depth.
REQ-003 SHALL have parameter DISPATCH_WIDTH, default 1, allocation lanes per cycle.
REQ-004 SHALL have parameter COMMIT_WIDTH, default 1, release lanes per cycle.
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port alloc_req_i, input, [DISPATCH_WIDTH], per-lane request for a new physical destination register.
REQ-008 SHALL have port alloc_valid_o, output, [DISPATCH_WIDTH], per-lane grant, combinational.
REQ-009 SHALL have port alloc_prf_o, output, [DISPATCH_WIDTH][$clog2(PHYS_REGS)], granted register; '0 when not granted.
REQ-010 SHALL have port free_count_o, output, $clog2(PHYS_REGS+1), registered count of free entries.
REQ-011 SHALL have port commit_valid_i, input, [COMMIT_WIDTH], retirement from the ROB.
REQ-012 SHALL have port commit_rd_wen_i, input, [COMMIT_WIDTH], retired instruction wrote a register.
REQ-013 SHALL have port commit_old_prf_i, input, [COMMIT_WIDTH][$clog2(PHYS_REGS)], superseded register to release.
REQ-014 SHALL have port flush_i, input, 1, misprediction/exception recovery from the ROB.

Function
REQ-015 SHALL store registers in an N-entry circular FIFO with pointers head (allocate), tail (release), and arch_head (retired allocations), each $clog2(N)+1 bits including a wrap bit.
REQ-016 SHALL define free count as tail-head and SHALL keep tail-arch_head == N at every clock edge.
REQ-017 SHALL grant lane i iff alloc_req_i[i], !flush_i, and free count exceeds the number of grants in lanes 0..i-1; grants to a lane are independent of higher lanes.
REQ-018 SHALL drive alloc_prf_o[i] = fifo[head+k], where k is the number of grants in lower lanes.
REQ-019 SHALL advance head by the number of grants at the clock edge, with zero-latency allocation in the same cycle.
REQ-020 SHALL, for each lane j with commit_valid_i[j] && commit_rd_wen_i[j], write commit_old_prf_i[j] at tail+m, where m is the number of qualifying lanes below j, and SHALL advance tail and arch_head by the qualifying count.
REQ-021 SHALL ignore commit lanes with rd_wen=0; these advance no pointer.
REQ-022 SHALL NOT make registers released in cycle t allocatable before cycle t+1; there is no release-to-allocate bypass.
REQ-023 SHALL, on flush_i, force all grants to 0, still process that cycle's commits, and set head to the updated arch_head, which returns every speculatively allocated register.
REQ-024 SHALL compute pointer arithmetic modulo 2N, index the FIFO with the low $clog2(N) bits, and handle wrap without bubbles.
REQ-025 SHALL update free_count_o at each edge as the post-update tail-head, with a maximum value of N.
REQ-026 SHALL, when empty, deny every request; when holding 1 entry with 2 requests, grant lane 0 only.

Reset
REQ-027 SHALL, on asynchronous reset, load fifo[i]=ARCH_REGS+i for i in 0..N-1 and set head=arch_head=0, tail=N with wrap bit 1, and free_count_o=N.
REQ-028 SHALL, while reset is asserted, drive alloc_valid_o=0 and alloc_prf_o='0.
REQ-029 SHALL, on reset mid-operation, discard all in-flight state and restore the REQ-027 values immediately.

Verification
REQ-030 SHALL verify: reset, then alloc_req_i=1 for 3 cycles -> alloc_prf_o=64,65,66; free_count_o=61.
REQ-031 SHALL verify: 64 consecutive allocations -> the 65th alloc_valid_o=0, free_count_o=0; one commit with rd_wen=1, old_prf=5 -> the next cycle grants 5.
REQ-032 SHALL verify: allocate 64,65,66, commit the one owning 64 (old_prf=3), then flush_i -> the next grants are 65,66,67…; free_count_o=N after recovery.
REQ-033 SHALL verify: a commit with rd_wen=0 and a simultaneous allocation -> tail is unchanged and free_count_o drops by 1.
REQ-034 SHALL verify: DISPATCH_WIDTH=2 with free_count_o=1 and both requests -> lane0 granted, lane1 denied.
REQ-035 SHALL verify: after more than 2N allocate/release cycles with pointer wrap -> no duplicate register is granted and the tail-arch_head==N invariant holds.
